// File: rtl/hilo_ctrl_if.sv
// EX-stage request/response bundle for the HI/LO sequencer.
// The pipeline side drives the instruction; the sequencer drives the status and results.
interface hilo_ctrl_if;
    logic        Valid;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Stall;
    logic [31:0] ReadData;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        DivByZero;

    modport master (
        output Valid, Op, A, B,
        input  Stall, ReadData, Hi, Lo, Busy, DivByZero
    );

    modport slave (
        input  Valid, Op, A, B,
        output Stall, ReadData, Hi, Lo, Busy, DivByZero
    );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: fixed-latency multiply/accumulate, 32-step restoring divide,
// HI/LO moves, and pipeline stall while a multi-cycle op is outstanding.
module hilo_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input logic        Clk,
    input logic        Reset,
    hilo_ctrl_if.slave bus
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMadd  = 4'd5;
    localparam logic [3:0] OpMaddu = 4'd6;
    localparam logic [3:0] OpMsub  = 4'd7;
    localparam logic [3:0] OpMsubu = 4'd8;
    localparam logic [3:0] OpMthi  = 4'd9;
    localparam logic [3:0] OpMtlo  = 4'd10;
    localparam logic [3:0] OpMfhi  = 4'd11;
    localparam logic [3:0] OpMflo  = 4'd12;

    typedef enum logic [1:0] {Idle, Mul, Div} stateType;
    typedef enum logic [1:0] {MulSet, MulAdd, MulSub} mulModeType;

    stateType   state;
    stateType   nextState;

    logic       busy;
    logic       stall;
    logic       accept;
    logic       isActive;
    logic       isMul;
    logic       isDiv;
    logic       mulSigned;
    logic       divSigned;
    logic       divZero;
    mulModeType opMode;

    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        divByZeroReg;

    logic [63:0] mulX;
    logic [63:0] mulY;
    logic [63:0] product;
    logic [63:0] hiLo;
    logic [63:0] mulResult;
    mulModeType  mulMode;
    logic [3:0]  mulCount;
    logic        mulDone;

    logic [31:0] divQ;
    logic [31:0] divR;
    logic [31:0] divD;
    logic [31:0] absA;
    logic [31:0] absB;
    logic [5:0]  divCount;
    logic        negQ;
    logic        negR;
    logic        divDone;
    logic [32:0] remShift;
    logic [32:0] trial;

    // Opcode decode; reserved codes 13-15 fall through as inactive, like NOP.
    always_comb begin
        isActive  = (bus.Op != 4'd0) && (bus.Op <= OpMflo);
        isMul     = 1'b0;
        mulSigned = 1'b0;
        opMode    = MulSet;
        case (bus.Op)
            OpMult:  begin isMul = 1'b1; mulSigned = 1'b1; end
            OpMultu: begin isMul = 1'b1; end
            OpMadd:  begin isMul = 1'b1; mulSigned = 1'b1; opMode = MulAdd; end
            OpMaddu: begin isMul = 1'b1; opMode = MulAdd; end
            OpMsub:  begin isMul = 1'b1; mulSigned = 1'b1; opMode = MulSub; end
            OpMsubu: begin isMul = 1'b1; opMode = MulSub; end
            default: ;
        endcase
        isDiv     = (bus.Op == OpDiv) || (bus.Op == OpDivu);
        divSigned = (bus.Op == OpDiv);
        divZero   = (bus.B == 32'd0);
        absA      = (divSigned && bus.A[31]) ? -bus.A : bus.A;
        absB      = (divSigned && bus.B[31]) ? -bus.B : bus.B;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= Idle;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            Idle: begin
                if (accept && isMul) begin
                    nextState = Mul;
                end else if (accept && isDiv && !divZero) begin
                    nextState = Div;
                end
            end
            Mul:     if (mulDone) nextState = Idle;
            Div:     if (divDone) nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    // Stall and accept both hinge on Busy, so the combinational read port sees only accepted moves.
    always_comb begin
        busy          = (state != Idle);
        stall         = bus.Valid && isActive && busy;
        accept        = bus.Valid && isActive && !busy;
        mulDone       = (state == Mul) && (mulCount == 4'd0);
        divDone       = (state == Div) && (divCount == 6'd32);
        bus.Busy      = busy;
        bus.Stall     = stall;
        bus.Hi        = hiReg;
        bus.Lo        = loReg;
        bus.DivByZero = divByZeroReg;
        bus.ReadData  = 32'd0;
        if (accept && bus.Op == OpMfhi) begin
            bus.ReadData = hiReg;
        end else if (accept && bus.Op == OpMflo) begin
            bus.ReadData = loReg;
        end
    end

    // Accumulating forms read HI/LO at completion; nothing else can write them while busy.
    always_comb begin
        product   = mulX * mulY;
        hiLo      = {hiReg, loReg};
        remShift  = {divR, divQ[31]};
        trial     = remShift - {1'b0, divD};
        case (mulMode)
            MulAdd:  mulResult = hiLo + product;
            MulSub:  mulResult = hiLo - product;
            default: mulResult = product;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mulX     <= 64'd0;
            mulY     <= 64'd0;
            mulMode  <= MulSet;
            mulCount <= 4'd0;
        end else if (accept && isMul) begin
            mulX     <= mulSigned ? {{32{bus.A[31]}}, bus.A} : {32'd0, bus.A};
            mulY     <= mulSigned ? {{32{bus.B[31]}}, bus.B} : {32'd0, bus.B};
            mulMode  <= opMode;
            mulCount <= 4'(MUL_CYCLES - 1);
        end else if (state == Mul && mulCount != 4'd0) begin
            mulCount <= mulCount - 4'd1;
        end
    end

    // Restoring divide on magnitudes: the dividend shifts out of divQ as quotient bits shift in.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            divQ     <= 32'd0;
            divR     <= 32'd0;
            divD     <= 32'd0;
            divCount <= 6'd0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
        end else if (accept && isDiv && !divZero) begin
            divQ     <= absA;
            divR     <= 32'd0;
            divD     <= absB;
            divCount <= 6'd0;
            negQ     <= divSigned && (bus.A[31] ^ bus.B[31]);
            negR     <= divSigned && bus.A[31];
        end else if (state == Div && divCount != 6'd32) begin
            if (!trial[32]) begin
                divR <= trial[31:0];
                divQ <= {divQ[30:0], 1'b1};
            end else begin
                divR <= remShift[31:0];
                divQ <= {divQ[30:0], 1'b0};
            end
            divCount <= divCount + 6'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hiReg <= 32'd0;
            loReg <= 32'd0;
        end else if (accept && bus.Op == OpMthi) begin
            hiReg <= bus.A;
        end else if (accept && bus.Op == OpMtlo) begin
            loReg <= bus.A;
        end else if (mulDone) begin
            hiReg <= mulResult[63:32];
            loReg <= mulResult[31:0];
        end else if (divDone) begin
            hiReg <= negR ? -divR : divR;
            loReg <= negQ ? -divQ : divQ;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            divByZeroReg <= 1'b0;
        end else begin
            divByZeroReg <= accept && isDiv && divZero;
        end
    end

endmodule
